mem_port_arbiter: RTL

- Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port (IF stage) and its data port (MEM stage), so the 5-stage CPU can run on a unified memory.
- Arbitrates between the two ports, sequences each access through an issue/wait/respond state machine, and returns registered read data.
- Drives stall requests that the pipeline controller folds into if_en/mem_en.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and data access.
// Optional performance counters are built when ARB_PERF_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inst_ren,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic                  inst_ready,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  data_ready,
   output logic                  stall_if,
   output logic                  stall_mem,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [31:0]           perf_inst_cnt,
   output logic [31:0]           perf_data_cnt,
   output logic [31:0]           perf_stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t                state_q, state_d;
   logic                  owner_inst_q, owner_inst_d;
   logic                  op_we_q, op_we_d;
   logic                  abort_q, abort_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic                  inst_ready_q, inst_ready_d;
   logic                  data_ready_q, data_ready_d;
   logic                  grant_inst, grant_data;
   logic                  data_req, owner_req;

   assign data_req  = mem_ren | mem_wen;
   assign owner_req = owner_inst_q ? inst_ren : data_req;

   always_comb begin
      state_d      = state_q;
      owner_inst_d = owner_inst_q;
      op_we_d      = op_we_q;
      abort_d      = abort_q;
      wait_cnt_d   = wait_cnt_q;
      starve_cnt_d = starve_cnt_q;
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      inst_data_d  = inst_data_q;
      mem_din_d    = mem_din_q;
      inst_ready_d = 1'b0;
      data_ready_d = 1'b0;
      grant_inst   = 1'b0;
      grant_data   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (data_req && (starve_cnt_q < STARVE_MAX)) begin
               grant_data = 1'b1;
            end else if (inst_ren) begin
               grant_inst = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
            if (grant_data || grant_inst) begin
               state_d      = S_ISSUE;
               owner_inst_d = grant_inst;
               op_we_d      = grant_data & mem_wen;
               abort_d      = 1'b0;
               ram_en_d     = 1'b1;
               ram_we_d     = grant_data & mem_wen;
               ram_addr_d   = grant_inst ? inst_addr : mem_addr;
               ram_wdata_d  = grant_data ? mem_dout : ram_wdata_q;
            end else begin
               ram_en_d = 1'b0;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = LAT_M1;
            state_d    = S_WAIT;
            abort_d    = abort_q | ~owner_req;
         end
         S_WAIT: begin
            abort_d = abort_q | ~owner_req;
            if (wait_cnt_q == 4'd0) begin
               // A dropped request still completes, but its ready pulse is withheld.
               if (!op_we_q && owner_inst_q) begin
                  inst_data_d = ram_rdata;
               end else if (!op_we_q) begin
                  mem_din_d = ram_rdata;
               end else begin
                  mem_din_d = mem_din_q;
               end
               inst_ready_d = owner_inst_q & owner_req & ~abort_q;
               data_ready_d = ~owner_inst_q & owner_req & ~abort_q;
               state_d      = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (!inst_ren) begin
         starve_cnt_d = 4'd0;
      end else if (grant_data) begin
         starve_cnt_d = (starve_cnt_q < STARVE_MAX) ? starve_cnt_q + 4'd1 : STARVE_MAX;
      end else if (grant_inst) begin
         starve_cnt_d = 4'd0;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_inst_q <= 1'b0;
         op_we_q      <= 1'b0;
         abort_q      <= 1'b0;
         wait_cnt_q   <= 4'd0;
         starve_cnt_q <= 4'd0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         inst_data_q  <= '0;
         mem_din_q    <= '0;
         inst_ready_q <= 1'b0;
         data_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_inst_q <= owner_inst_d;
         op_we_q      <= op_we_d;
         abort_q      <= abort_d;
         wait_cnt_q   <= wait_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         inst_data_q  <= inst_data_d;
         mem_din_q    <= mem_din_d;
         inst_ready_q <= inst_ready_d;
         data_ready_q <= data_ready_d;
      end
   end

   assign inst_data  = inst_data_q;
   assign inst_ready = inst_ready_q;
   assign mem_din    = mem_din_q;
   assign data_ready = data_ready_q;
   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign stall_if   = inst_ren & ~inst_ready_q;
   assign stall_mem  = data_req & ~data_ready_q;

`ifdef ARB_PERF_EN
   logic [31:0] perf_inst_q, perf_inst_d;
   logic [31:0] perf_data_q, perf_data_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_inst_d  = perf_inst_q + {31'd0, grant_inst};
      perf_data_d  = perf_data_q + {31'd0, grant_data};
      perf_stall_d = perf_stall_q + {31'd0, (stall_if | stall_mem)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_inst_q  <= 32'd0;
         perf_data_q  <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_inst_q  <= perf_inst_d;
         perf_data_q  <= perf_data_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_inst_cnt  = perf_inst_q;
   assign perf_data_cnt  = perf_data_q;
   assign perf_stall_cnt = perf_stall_q;
`else
   assign perf_inst_cnt  = 32'd0;
   assign perf_data_cnt  = 32'd0;
   assign perf_stall_cnt = 32'd0;
`endif

endmodule
